mem_arbiter_n: RTL and testbench
================================

Name: mem_arbiter_n

Overview:
- Parametrised successor to the fixed 4-port memory controller.
- Arbitrates N cores' read/write requests onto one single-port synchronous RAM (IRAM or DRAM) using round-robin with a hold-timeout starvation guard.
- Returns read data per requester with a valid pulse.
- Sits between the core instances and each shared RAM in the multi-core top level.

Parameters:
N, 4, number of requesters (2..16)
AW, 8, address width
DW, 8, data width
MAX_HOLD, 16, max consecutive grant cycles while others wait; 0 disables timeout
IDW, $clog2(N), owner index width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
rden  in  N  per-requester read request
wren  in  N  per-requester write request
Address  in  N*AW  requester i at [i*AW +: AW]
Din  in  N*DW  requester i write data at [i*DW +: DW]
RAMq  in  DW  RAM read data, valid the cycle after the address is presented
acq  out  N  one-hot grant (registered)
Dq  out  N*DW  per-requester read data registers
dvalid  out  N  one-cycle pulse: Dq[i] updated
RAMAddress  out  AW  to RAM
RAMDin  out  DW  to RAM
RAMwren  out  1  to RAM
owner  out  IDW  index of current grantee (0 when idle)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset: acq=0, Dq=0, dvalid=0, owner=0, rr_ptr=0, hold_cnt=0, state=IDLE. RAMwren drops immediately because it is derived from acq. A write in flight is abandoned. A pending read is discarded with no dvalid.
- req[i] = rden[i] | wren[i].
- States: IDLE, OWN.
- IDLE: if any req, pick the first i at or after rr_ptr cyclically. Next edge: acq=1<<i, owner=i, hold_cnt=0, state=OWN.
- OWN(k), per edge:
  - req[k]=0 and another req pending: grant the next requester after k cyclically. No idle bubble. rr_ptr=k+1 mod N.
  - req[k]=0 and none pending: state=IDLE, acq=0, rr_ptr=k+1 mod N.
  - req[k]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, other req pending: forced release to the next requester after k. k must re-request and wait its turn.
  - Otherwise hold. hold_cnt increments and saturates at MAX_HOLD-1.
- RAM mux (combinational from the registered grant):
  - When acq[k]=1: RAMAddress=Address[k], RAMDin=Din[k], RAMwren=wren[k].
  - When no grant: all three are 0.
- Access timing: one access per granted cycle. A requester may change address every cycle while granted (burst).
- rden and wren together: write wins, no read issued.
- Read pipeline:
  - Edge t: rd_v<=acq[k]&rden[k]&~wren[k], rd_id<=k.
  - Cycle t+1: RAMq valid.
  - Edge t+2: Dq[rd_id]<=RAMq, dvalid[rd_id]=1 for one cycle.
  - Latency: read presented in granted cycle t gives dvalid in cycle t+2.
  - Dq holds its value until the next read for that requester.
  - Grant change does not cancel an in-flight read; the data is still delivered to the issuer.
- Requests arriving while another requester is granted wait. No request is queued beyond the level of rden/wren.
- N=1: always grants requester 0, never times out.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, OWN), width helper for IDW, per-slice index helpers.
- One sub-module, rr_pick: combinational; takes req[N] and start pointer, returns found and index of the first set bit cyclically from the pointer. Used for both IDLE and release selection.

Test Plan:
- Reset mid-write: wren[1]=1, acq[1]=1, assert rst → RAMwren=0 same cycle, acq=0, Dq all 0, no dvalid after release.
- Single read: core2 rden, Address=8'h10, RAM holds 8'hA5 at 8'h10 → acq=4'b0100 next edge; dvalid[2] two cycles after the first granted cycle; Dq[2]=8'hA5.
- Round-robin: all four request continuously, each drops after 1 granted cycle, MAX_HOLD=16 → grant order 0,1,2,3,0 with no idle cycle.
- Starvation guard: core0 holds req, core3 requests, MAX_HOLD=4 → core0 granted exactly 4 cycles, then acq=4'b1000.
- Write-then-read: core1 writes 8'h3C to 8'h20, then reads 8'h20 in the next granted cycle → Dq[1]=8'h3C. Simultaneous rden+wren on core1 → RAMwren=1, no dvalid[1].
- Parametrisation: N=8, AW=10, DW=16; requester 7 reads 10'h3FF holding 16'hBEEF → Dq slice [127:112]=16'hBEEF, owner=7.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and index helpers for the N-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, OWN} arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_pick.sv
// Cyclic first-set-bit search: the first requester at or after start.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idx_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [2*N-1:0] dbl;

  assign dbl = {req, req} >> start;

  always_comb begin
    int p;
    p     = 0;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        p     = int'(start) + j;
        if (p >= N) p = p - N;
        idx = IDW'(p);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// Round-robin arbiter sharing one single-port synchronous RAM among N requesters,
// with a hold-timeout guard and a registered per-requester read return.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int  N        = 4,
  parameter int  AW       = 8,
  parameter int  DW       = 8,
  parameter int  MAX_HOLD = 16,
  localparam int IDW      = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    rden,
  input  logic [N-1:0]    wren,
  input  logic [N*AW-1:0] Address,
  input  logic [N*DW-1:0] Din,
  input  logic [DW-1:0]   RAMq,
  output logic [N-1:0]    acq,
  output logic [N*DW-1:0] Dq,
  output logic [N-1:0]    dvalid,
  output logic [AW-1:0]   RAMAddress,
  output logic [DW-1:0]   RAMDin,
  output logic            RAMwren,
  output logic [IDW-1:0]  owner
);

  localparam int HCW = idx_w(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_t     state;
  logic [IDW-1:0] rr_ptr;
  logic [HCW-1:0] hold_cnt;
  logic [N-1:0]   req;
  logic [N-1:0]   pick_req;
  logic [N-1:0]   pick_oh;
  logic [IDW-1:0] pick_start;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] owner_inc;
  logic           pick_found;
  logic           own_req;
  logic           timeout;
  logic           rd_issue;
  logic           rd_vld_p0;
  logic [IDW-1:0] rd_id_p0;

  assign req        = rden | wren;
  assign own_req    = |(req & acq);
  assign owner_inc  = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
  assign pick_req   = (state == OWN) ? (req & ~acq) : req;
  assign pick_start = (state == OWN) ? owner_inc : rr_ptr;
  assign timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < N; i++) pick_oh[i] = (pick_idx == IDW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acq      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= OWN;
            acq      <= pick_oh;
            owner    <= pick_idx;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          // Voluntary release, or forced release once the owner has held too long.
          if (!own_req || (timeout && pick_found)) begin
            rr_ptr   <= owner_inc;
            hold_cnt <= '0;
            if (pick_found) begin
              acq   <= pick_oh;
              owner <= pick_idx;
            end else begin
              state <= IDLE;
              acq   <= '0;
              owner <= '0;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    RAMAddress = '0;
    RAMDin     = '0;
    RAMwren    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (acq[i]) begin
        RAMAddress = Address[slice_lo(i, AW) +: AW];
        RAMDin     = Din[slice_lo(i, DW) +: DW];
        RAMwren    = wren[i];
      end
    end
  end

  // Stage p0: read issued in the granted cycle; RAM data arrives during the next cycle.
  assign rd_issue = |(acq & rden & ~wren);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_vld_p0 <= 1'b0;
    else     rd_vld_p0 <= rd_issue;
  end

  always_ff @(posedge clk) begin
    rd_id_p0 <= owner;
  end

  // Stage p1: capture RAM data into the issuing requester's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Dq     <= '0;
      dvalid <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        dvalid[i] <= rd_vld_p0 && (rd_id_p0 == IDW'(i));
        if (rd_vld_p0 && (rd_id_p0 == IDW'(i))) Dq[slice_lo(i, DW) +: DW] <= RAMq;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: behavioural arbitration/RAM model plus directed literal checks.
module tb_mem_arbiter_n;

  localparam int N = 4, AW = 8, DW = 8, MH = 4;
  localparam int NB = 8, AWB = 10, DWB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    rden, wren, acq, dvalid;
  logic [N*AW-1:0] Address;
  logic [N*DW-1:0] Din, Dq;
  logic [DW-1:0]   RAMq, RAMDin;
  logic [AW-1:0]   RAMAddress;
  logic            RAMwren;
  logic [1:0]      owner;

  logic [NB-1:0]     rden_b, wren_b, acq_b, dvalid_b;
  logic [NB*AWB-1:0] Address_b;
  logic [NB*DWB-1:0] Din_b, Dq_b;
  logic [DWB-1:0]    RAMq_b, RAMDin_b;
  logic [AWB-1:0]    RAMAddress_b;
  logic              RAMwren_b;
  logic [2:0]        owner_b;

  mem_arbiter_n #(.N(N), .AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .rden(rden), .wren(wren), .Address(Address), .Din(Din),
    .RAMq(RAMq), .acq(acq), .Dq(Dq), .dvalid(dvalid), .RAMAddress(RAMAddress),
    .RAMDin(RAMDin), .RAMwren(RAMwren), .owner(owner)
  );

  mem_arbiter_n #(.N(NB), .AW(AWB), .DW(DWB), .MAX_HOLD(16)) dut_b (
    .clk(clk), .rst(rst), .rden(rden_b), .wren(wren_b), .Address(Address_b), .Din(Din_b),
    .RAMq(RAMq_b), .acq(acq_b), .Dq(Dq_b), .dvalid(dvalid_b), .RAMAddress(RAMAddress_b),
    .RAMDin(RAMDin_b), .RAMwren(RAMwren_b), .owner(owner_b)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] pat_a(input int a);
    return (a == 16) ? 8'hA5 : 8'(a * 7 + 3);
  endfunction

  function automatic logic [15:0] pat_b(input int a);
    return (a == 1023) ? 16'hBEEF : 16'(a * 13 + 1);
  endfunction

  function automatic logic [1:0] wrap(input int v);
    return 2'(v % N);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAMs: data for the presented address appears after the next edge.
  logic [7:0]  ram  [256];
  logic [15:0] ramb [1024];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = pat_a(i);
    forever begin
      @(posedge clk);
      if (RAMwren) ram[RAMAddress] <= RAMDin;
      RAMq <= ram[RAMAddress];
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) ramb[i] = pat_b(i);
    forever begin
      @(posedge clk);
      if (RAMwren_b) ramb[RAMAddress_b] <= RAMDin_b;
      RAMq_b <= ramb[RAMAddress_b];
    end
  end

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] din_a  [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_a[i] = Address[i*AW +: AW];
      din_a[i]  = Din[i*DW +: DW];
    end
  end

  // Reference model: who owns the RAM, how long, what memory holds, what reads return.
  logic [7:0]   mm [256];
  logic         m_own, pend_v;
  logic [1:0]   m_k, m_rr, pend_id, ci;
  int           m_cyc, nxt;
  logic [7:0]   pend_d;
  logic [N-1:0] m_dv, m_req;
  logic [7:0]   m_dq [N];

  task automatic model_reset;
    m_own = 1'b0; m_k = '0; m_rr = '0; m_cyc = 0;
    pend_v = 1'b0; pend_id = '0; pend_d = '0; m_dv = '0;
    for (int i = 0; i < N; i++) m_dq[i] = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = pat_a(i);
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_req = rden | wren;
        m_dv  = '0;
        if (pend_v) begin
          m_dv[pend_id]  = 1'b1;
          m_dq[pend_id]  = pend_d;
        end
        pend_v = 1'b0;
        if (m_own) begin
          if (wren[m_k]) mm[addr_a[m_k]] = din_a[m_k];
          else if (rden[m_k]) begin
            pend_v = 1'b1; pend_id = m_k; pend_d = mm[addr_a[m_k]];
          end
        end
        nxt = -1;
        if (!m_own) begin
          for (int j = 0; j < N; j++) begin
            ci = wrap(int'(m_rr) + j);
            if (nxt < 0 && m_req[ci]) nxt = int'(ci);
          end
          if (nxt >= 0) begin m_own = 1'b1; m_k = wrap(nxt); m_cyc = 1; end
        end else begin
          for (int j = 1; j < N; j++) begin
            ci = wrap(int'(m_k) + j);
            if (nxt < 0 && m_req[ci]) nxt = int'(ci);
          end
          if (!m_req[m_k]) begin
            m_rr = wrap(int'(m_k) + 1);
            if (nxt >= 0) begin m_k = wrap(nxt); m_cyc = 1; end
            else m_own = 1'b0;
          end else if (MH != 0 && m_cyc >= MH && nxt >= 0) begin
            m_rr = wrap(int'(m_k) + 1); m_k = wrap(nxt); m_cyc = 1;
          end else begin
            m_cyc++;
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0]    e_acq;
    logic [N*DW-1:0] e_dq;
    forever begin
      @(negedge clk);
      e_acq = m_own ? (4'b0001 << m_k) : 4'b0000;
      for (int i = 0; i < N; i++) e_dq[i*DW +: DW] = m_dq[i];
      chk("acq", acq, e_acq);
      chk("owner", owner, m_own ? m_k : 2'd0);
      chk("ram_bus", {RAMwren, RAMAddress, RAMDin},
          m_own ? {wren[m_k], addr_a[m_k], din_a[m_k]} : 17'd0);
      chk("dvalid", dvalid, m_dv);
      chk("Dq", Dq, e_dq);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst;
    #2 rst = 1'b1;
    tick();
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    int hold;
    int order [5] = '{0, 1, 2, 3, 0};
    rden = '0; wren = '0; Address = '0; Din = '0;
    rden_b = '0; wren_b = '0; Address_b = '0; Din_b = '0;
    tick(); tick();
    chk("rst_acq", acq, 4'b0000);
    chk("rst_owner", owner, 2'd0);
    chk("rst_dvalid", dvalid, 4'b0000);
    chk("rst_Dq", Dq, 32'h0);
    #2 rst = 1'b0;
    tick();

    rden = 4'b0100; Address[2*AW +: AW] = 8'h10;
    tick();
    chk("rd_acq", acq, 4'b0100);
    chk("rd_owner", owner, 2'd2);
    tick();
    rden = '0;
    tick();
    chk("rd_dvalid", dvalid, 4'b0100);
    chk("rd_Dq2", Dq[2*DW +: DW], 8'hA5);
    tick();
    chk("rd_pulse", dvalid, 4'b0000);

    pulse_rst();
    rden = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("rr_order", acq, 4'b0001 << order[j]);
      rden = 4'b1111 & ~(4'b0001 << order[j]);
    end
    rden = '0;
    tick(); tick();

    pulse_rst();
    rden = 4'b0001;
    tick();
    chk("starve_first", acq, 4'b0001);
    rden = 4'b1001;
    hold = 1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (acq != 4'b0001) break;
      hold++;
    end
    chk("starve_hold", hold, 4);
    chk("starve_next", acq, 4'b1000);
    rden = '0;
    tick(); tick();

    wren = 4'b0010; Address[1*AW +: AW] = 8'h20; Din[1*DW +: DW] = 8'h3C;
    tick();
    chk("wr_acq", acq, 4'b0010);
    chk("wr_bus", {RAMwren, RAMAddress, RAMDin}, {1'b1, 8'h20, 8'h3C});
    tick();
    wren = '0; rden = 4'b0010;
    tick();
    rden = '0;
    tick();
    chk("wr_rd_dvalid", dvalid, 4'b0010);
    chk("wr_rd_Dq1", Dq[1*DW +: DW], 8'h3C);
    tick();

    rden = 4'b0010; wren = 4'b0010; Address[1*AW +: AW] = 8'h30; Din[1*DW +: DW] = 8'h77;
    tick();
    chk("rw_wren", RAMwren, 1'b1);
    tick();
    rden = '0; wren = '0;
    tick();
    chk("rw_no_dv_a", dvalid, 4'b0000);
    tick();
    chk("rw_no_dv_b", dvalid, 4'b0000);
    chk("rw_ram", ram[8'h30], 8'h77);

    wren = 4'b0010; Address[1*AW +: AW] = 8'h40; Din[1*DW +: DW] = 8'h99;
    tick();
    chk("mid_acq", acq, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("mid_wren", RAMwren, 1'b0);
    chk("mid_acq0", acq, 4'b0000);
    chk("mid_Dq0", Dq, 32'h0);
    chk("mid_dv0", dvalid, 4'b0000);
    wren = '0;
    tick();
    #2 rst = 1'b0;
    tick(); tick();
    chk("mid_ram", ram[8'h40], pat_a(64));
    chk("mid_dv_after", dvalid, 4'b0000);

    rden_b = 8'h80; Address_b[7*AWB +: AWB] = 10'h3FF;
    tick();
    chk("b_owner", owner_b, 3'd7);
    chk("b_acq", acq_b, 8'h80);
    tick();
    rden_b = '0;
    tick();
    chk("b_dvalid", dvalid_b, 8'h80);
    chk("b_Dq7", Dq_b[127:112], 16'hBEEF);

    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 20) rden[i] = ~rden[i];
        wren[i] = ($urandom_range(0, 99) < 15);
        Address[i*AW +: AW] = 8'h80 + 8'($urandom_range(0, 7));
        Din[i*DW +: DW] = 8'($urandom);
      end
      if (c == 200) begin
        #2 rst = 1'b1;
        tick();
        #2 rst = 1'b0;
      end
    end
    rden = '0; wren = '0;
    tick(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
